// File: rtl/decode_stage_pkg.sv
// Shared RISC16 definitions: opcode encodings, instruction field positions and small
// decode predicates used by the decode stage.
`ifndef RISC16_DEFS_VH
`define RISC16_DEFS_VH

package decode_stage_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_e;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 13;
  localparam int unsigned RA_MSB   = 12;
  localparam int unsigned RA_LSB   = 10;
  localparam int unsigned RB_MSB   = 9;
  localparam int unsigned RB_LSB   = 7;
  localparam int unsigned RC_MSB   = 2;
  localparam int unsigned RC_LSB   = 0;
  localparam int unsigned IMM7_MSB = 6;
  localparam int unsigned LUI_MSB  = 9;

  function automatic logic op_writes_reg(input opcode_e op);
    return (op != OP_SW) && (op != OP_BEQ);
  endfunction

  function automatic logic op_uses_src2(input opcode_e op);
    return (op == OP_ADD) || (op == OP_NAND) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

`endif

// File: rtl/decode_stage_fwd_mux.sv
// Operand bypass selector: youngest in-flight writer wins, register file last,
// and an unused or r0 source always reads as zero.
module fwd_mux #(
  parameter int W = 16
) (
  input  logic [2:0]   i_addr,
  input  logic         i_used,
  input  logic [W-1:0] i_rf_data,
  input  logic [2:0]   i_ex_tgt,
  input  logic         i_ex_wr_en,
  input  logic [W-1:0] i_ex_result,
  input  logic [2:0]   i_mem_tgt,
  input  logic         i_mem_wr_en,
  input  logic [W-1:0] i_mem_result,
  input  logic [2:0]   i_wb_tgt,
  input  logic         i_wb_wr_en,
  input  logic [W-1:0] i_wb_result,
  output logic [W-1:0] o_data
);

  always_comb begin
    o_data = i_rf_data;
    if (!i_used || (i_addr == 3'd0)) begin
      o_data = '0;
    end else if (i_ex_wr_en && (i_ex_tgt == i_addr)) begin
      o_data = i_ex_result;
    end else if (i_mem_wr_en && (i_mem_tgt == i_addr)) begin
      o_data = i_mem_result;
    end else if (i_wb_wr_en && (i_wb_tgt == i_addr)) begin
      o_data = i_wb_result;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RISC16 decode stage: field decode, operand bypass, load-use hazard detection,
// and the ID/EX pipeline register (the only state in this block).
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int p_WORD_LEN     = 16,
  parameter int p_REG_ADDR_LEN = 3,
  parameter int p_PC_LEN       = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [15:0]               i_instr,
  input  logic [p_PC_LEN-1:0]       i_pc,
  input  logic                      i_valid,
  output logic [p_REG_ADDR_LEN-1:0] o_src1,
  output logic [p_REG_ADDR_LEN-1:0] o_src2,
  input  logic [p_WORD_LEN-1:0]     i_src1_data,
  input  logic [p_WORD_LEN-1:0]     i_src2_data,
  input  logic [2:0]                i_ex_tgt,
  input  logic                      i_ex_wr_en,
  input  logic [p_WORD_LEN-1:0]     i_ex_result,
  input  logic                      i_ex_is_load,
  input  logic [2:0]                i_mem_tgt,
  input  logic                      i_mem_wr_en,
  input  logic [p_WORD_LEN-1:0]     i_mem_result,
  input  logic [2:0]                i_wb_tgt,
  input  logic                      i_wb_wr_en,
  input  logic [p_WORD_LEN-1:0]     i_wb_result,
  input  logic                      i_flush,
  input  logic                      i_stall,
  output logic                      o_stall,
  output logic                      o_valid,
  output logic [2:0]                o_op,
  output logic [2:0]                o_tgt,
  output logic                      o_wr_en,
  output logic [p_WORD_LEN-1:0]     o_op1,
  output logic [p_WORD_LEN-1:0]     o_op2,
  output logic [p_WORD_LEN-1:0]     o_sw_data,
  output logic [p_WORD_LEN-1:0]     o_imm,
  output logic [p_PC_LEN-1:0]       o_pc
);

  opcode_e op;
  logic [2:0] ra, rb, rc;
  logic [2:0] src_addr [2];
  logic       src_used [2];
  logic [p_WORD_LEN-1:0] src_rf [2];
  logic [p_WORD_LEN-1:0] src_val [2];
  logic [p_WORD_LEN-1:0] imm;
  logic wr_en_dec;
  logic load_use;

  assign op = opcode_e'(i_instr[OP_MSB:OP_LSB]);
  assign ra = i_instr[RA_MSB:RA_LSB];
  assign rb = i_instr[RB_MSB:RB_LSB];
  assign rc = i_instr[RC_MSB:RC_LSB];

  always_comb begin
    src_addr[0] = (op == OP_BEQ) ? ra : rb;
    src_used[0] = (op != OP_LUI);
    src_used[1] = op_uses_src2(op);
    case (op)
      OP_ADD, OP_NAND: src_addr[1] = rc;
      OP_SW:           src_addr[1] = ra;
      OP_BEQ:          src_addr[1] = rb;
      default:         src_addr[1] = 3'd0;
    endcase
  end

  always_comb begin
    case (op)
      OP_ADDI, OP_SW, OP_LW, OP_BEQ:
        imm = {{(p_WORD_LEN-7){i_instr[IMM7_MSB]}}, i_instr[IMM7_MSB:0]};
      OP_LUI:
        imm = p_WORD_LEN'({i_instr[LUI_MSB:0], 6'b0});
      default:
        imm = '0;
    endcase
  end

  assign wr_en_dec = op_writes_reg(op) && (ra != 3'd0);

  assign o_src1 = p_REG_ADDR_LEN'(src_addr[0]);
  assign o_src2 = p_REG_ADDR_LEN'(src_addr[1]);
  assign src_rf[0] = i_src1_data;
  assign src_rf[1] = i_src2_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_mux #(.W(p_WORD_LEN)) u_fwd (
        .i_addr      (src_addr[gi]),
        .i_used      (src_used[gi]),
        .i_rf_data   (src_rf[gi]),
        .i_ex_tgt    (i_ex_tgt),
        .i_ex_wr_en  (i_ex_wr_en),
        .i_ex_result (i_ex_result),
        .i_mem_tgt   (i_mem_tgt),
        .i_mem_wr_en (i_mem_wr_en),
        .i_mem_result(i_mem_result),
        .i_wb_tgt    (i_wb_tgt),
        .i_wb_wr_en  (i_wb_wr_en),
        .i_wb_result (i_wb_result),
        .o_data      (src_val[gi])
      );
    end
  endgenerate

  // A load in EX cannot be bypassed; hold IF/ID until the value reaches MEM.
  assign load_use = i_valid && i_ex_wr_en && i_ex_is_load && (i_ex_tgt != 3'd0) &&
                    ((src_used[0] && (i_ex_tgt == src_addr[0])) ||
                     (src_used[1] && (i_ex_tgt == src_addr[1])));
  assign o_stall = load_use && !i_rst;

  logic                  valid_q, valid_d;
  logic [2:0]            op_q, op_d;
  logic [2:0]            tgt_q, tgt_d;
  logic                  wr_en_q, wr_en_d;
  logic [p_WORD_LEN-1:0] op1_q, op1_d;
  logic [p_WORD_LEN-1:0] op2_q, op2_d;
  logic [p_WORD_LEN-1:0] sw_data_q, sw_data_d;
  logic [p_WORD_LEN-1:0] imm_q, imm_d;
  logic [p_PC_LEN-1:0]   pc_q, pc_d;

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    tgt_d     = tgt_q;
    wr_en_d   = wr_en_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sw_data_d = sw_data_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    if (i_flush || (!i_stall && (load_use || !i_valid))) begin
      valid_d   = 1'b0;
      op_d      = '0;
      tgt_d     = '0;
      wr_en_d   = 1'b0;
      op1_d     = '0;
      op2_d     = '0;
      sw_data_d = '0;
      imm_d     = '0;
      pc_d      = '0;
    end else if (!i_stall) begin
      valid_d   = 1'b1;
      op_d      = op;
      tgt_d     = wr_en_dec ? ra : 3'd0;
      wr_en_d   = wr_en_dec;
      op1_d     = src_val[0];
      op2_d     = (op == OP_SW) ? '0 : src_val[1];
      sw_data_d = (op == OP_SW) ? src_val[1] : '0;
      imm_d     = imm;
      pc_d      = i_pc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      tgt_q     <= '0;
      wr_en_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      sw_data_q <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      tgt_q     <= tgt_d;
      wr_en_q   <= wr_en_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      sw_data_q <= sw_data_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_op      = op_q;
  assign o_tgt     = tgt_q;
  assign o_wr_en   = wr_en_q;
  assign o_op1     = op1_q;
  assign o_op2     = op2_q;
  assign o_sw_data = sw_data_q;
  assign o_imm     = imm_q;
  assign o_pc      = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against an instruction-level
// reference model (register values, bypass priority, hazard and pipeline-register rules).
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr, pc;
  logic        valid;
  logic [2:0]  src1, src2;
  logic [15:0] src1_data, src2_data;
  logic [2:0]  ex_tgt, mem_tgt, wb_tgt;
  logic        ex_we, mem_we, wb_we, ex_ld;
  logic [15:0] ex_res, mem_res, wb_res;
  logic        flush, stall, o_stall;
  logic        o_valid, o_wr_en;
  logic [2:0]  o_op, o_tgt;
  logic [15:0] o_op1, o_op2, o_sw_data, o_imm, o_pc;

  always #5 clk = ~clk;

  logic [15:0] rf [8];
  assign src1_data = rf[src1];
  assign src2_data = rf[src2];

  decode_stage dut (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_pc(pc), .i_valid(valid),
    .o_src1(src1), .o_src2(src2), .i_src1_data(src1_data), .i_src2_data(src2_data),
    .i_ex_tgt(ex_tgt), .i_ex_wr_en(ex_we), .i_ex_result(ex_res), .i_ex_is_load(ex_ld),
    .i_mem_tgt(mem_tgt), .i_mem_wr_en(mem_we), .i_mem_result(mem_res),
    .i_wb_tgt(wb_tgt), .i_wb_wr_en(wb_we), .i_wb_result(wb_res),
    .i_flush(flush), .i_stall(stall), .o_stall(o_stall),
    .o_valid(o_valid), .o_op(o_op), .o_tgt(o_tgt), .o_wr_en(o_wr_en),
    .o_op1(o_op1), .o_op2(o_op2), .o_sw_data(o_sw_data), .o_imm(o_imm), .o_pc(o_pc)
  );

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [2:0]  tgt;
    logic        we;
    logic [15:0] op1, op2, sw, imm, pc;
  } idex_t;

  idex_t exp_q;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic idex_t bubble();
    idex_t z;
    z.v = 1'b0; z.op = 3'd0; z.tgt = 3'd0; z.we = 1'b0;
    z.op1 = 16'd0; z.op2 = 16'd0; z.sw = 16'd0; z.imm = 16'd0; z.pc = 16'd0;
    return z;
  endfunction

  // Architectural value of register r as seen by the instruction in decode.
  function automatic logic [15:0] rval(input logic [2:0] r);
    if (r == 3'd0) return 16'd0;
    if (ex_we && ex_tgt == r) return ex_res;
    if (mem_we && mem_tgt == r) return mem_res;
    if (wb_we && wb_tgt == r) return wb_res;
    return rf[r];
  endfunction

  function automatic void model(output logic [2:0] s1, output logic [2:0] s2,
                                output logic hz, output idex_t d);
    logic [2:0] op, ra, rb, rc;
    logic u1, u2;
    logic [15:0] simm;
    op = instr[15:13]; ra = instr[12:10]; rb = instr[9:7]; rc = instr[2:0];
    simm = {{9{instr[6]}}, instr[6:0]};
    d = bubble();
    d.v = 1'b1; d.op = op; d.pc = pc;
    s1 = rb; s2 = 3'd0; u1 = 1'b1; u2 = 1'b0;
    case (op)
      3'd0, 3'd2: begin s2 = rc; u2 = 1'b1; d.op1 = rval(rb); d.op2 = rval(rc); d.we = 1'b1; end
      3'd1: begin d.op1 = rval(rb); d.imm = simm; d.we = 1'b1; end
      3'd3: begin u1 = 1'b0; d.imm = {instr[9:0], 6'b0}; d.we = 1'b1; end
      3'd4: begin s2 = ra; u2 = 1'b1; d.op1 = rval(rb); d.sw = rval(ra); d.imm = simm; end
      3'd5: begin d.op1 = rval(rb); d.imm = simm; d.we = 1'b1; end
      3'd6: begin s1 = ra; s2 = rb; u2 = 1'b1; d.op1 = rval(ra); d.op2 = rval(rb); d.imm = simm; end
      default: begin d.op1 = rval(rb); d.we = 1'b1; end
    endcase
    if (ra == 3'd0) d.we = 1'b0;
    d.tgt = d.we ? ra : 3'd0;
    hz = valid && ex_we && ex_ld && ex_tgt != 3'd0 &&
         ((u1 && ex_tgt == s1) || (u2 && ex_tgt == s2));
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".valid"}, 32'(o_valid), 32'(exp_q.v));
    check({tag, ".op"}, 32'(o_op), 32'(exp_q.op));
    check({tag, ".tgt"}, 32'(o_tgt), 32'(exp_q.tgt));
    check({tag, ".wr_en"}, 32'(o_wr_en), 32'(exp_q.we));
    check({tag, ".op1"}, 32'(o_op1), 32'(exp_q.op1));
    check({tag, ".op2"}, 32'(o_op2), 32'(exp_q.op2));
    check({tag, ".sw_data"}, 32'(o_sw_data), 32'(exp_q.sw));
    check({tag, ".imm"}, 32'(o_imm), 32'(exp_q.imm));
    check({tag, ".pc"}, 32'(o_pc), 32'(exp_q.pc));
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag);
    logic [2:0] s1, s2;
    logic hz;
    idex_t d;
    #1;
    model(s1, s2, hz, d);
    check({tag, ".src1"}, 32'(src1), 32'(s1));
    check({tag, ".src2"}, 32'(src2), 32'(s2));
    check({tag, ".stall"}, 32'(o_stall), 32'(hz));
    if (flush) exp_q = bubble();
    else if (stall) exp_q = exp_q;
    else if (hz || !valid) exp_q = bubble();
    else exp_q = d;
    @(posedge clk); #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    exp_q = bubble();
    check_regs({tag, ".async"});
    check({tag, ".stall"}, 32'(o_stall), 32'd0);
    @(posedge clk); #1;
    check_regs({tag, ".edge"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    instr = 16'd0; pc = 16'd0; valid = 1'b0;
    ex_tgt = 3'd0; mem_tgt = 3'd0; wb_tgt = 3'd0;
    ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0; ex_ld = 1'b0;
    ex_res = 16'd0; mem_res = 16'd0; wb_res = 16'd0;
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic rand_inputs();
    instr = 16'($urandom); pc = 16'($urandom);
    valid = ($urandom_range(0, 9) != 0);
    ex_tgt = 3'($urandom_range(0, 7)); ex_we = 1'($urandom_range(0, 1));
    ex_ld = ($urandom_range(0, 2) == 0); ex_res = 16'($urandom);
    mem_tgt = 3'($urandom_range(0, 7)); mem_we = 1'($urandom_range(0, 1)); mem_res = 16'($urandom);
    wb_tgt = 3'($urandom_range(0, 7)); wb_we = 1'($urandom_range(0, 1)); wb_res = 16'($urandom);
    flush = ($urandom_range(0, 11) == 0);
    stall = ($urandom_range(0, 6) == 0);
    rf[$urandom_range(1, 7)] = 16'($urandom);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h0111);
    rf[0] = 16'd0;
    apply_reset("reset");

    // ADD r3,r1,r2 straight from the register file
    rf[1] = 16'd5; rf[2] = 16'd7;
    instr = {3'b000, 3'd3, 3'd1, 4'b0, 3'd2}; pc = 16'h0040; valid = 1'b1;
    step("add_rf");
    check("add_rf.op1_abs", 32'(o_op1), 32'd5);
    check("add_rf.op2_abs", 32'(o_op2), 32'd7);
    check("add_rf.tgt_abs", 32'(o_tgt), 32'd3);

    // Bypass priority: EX beats MEM for r1, WB supplies r2
    ex_tgt = 3'd1; ex_we = 1'b1; ex_res = 16'd9;
    mem_tgt = 3'd1; mem_we = 1'b1; mem_res = 16'd4;
    wb_tgt = 3'd2; wb_we = 1'b1; wb_res = 16'd6;
    step("add_fwd");
    check("add_fwd.op1_abs", 32'(o_op1), 32'd9);
    check("add_fwd.op2_abs", 32'(o_op2), 32'd6);

    // Load-use on r2, then the hazard clears and the instruction issues
    clear_inputs();
    instr = {3'b000, 3'd3, 3'd1, 4'b0, 3'd2}; valid = 1'b1; pc = 16'h0044;
    ex_tgt = 3'd2; ex_we = 1'b1; ex_ld = 1'b1;
    step("load_use");
    check("load_use.valid_abs", 32'(o_valid), 32'd0);
    ex_ld = 1'b0; ex_we = 1'b0;
    step("load_use_clear");
    check("load_use_clear.valid_abs", 32'(o_valid), 32'd1);

    // Immediates, and r0 never forwarded
    instr = {3'b011, 3'd4, 10'h3FF};
    step("lui");
    check("lui.imm_abs", 32'(o_imm), 32'hFFC0);
    instr = {3'b001, 3'd1, 3'd0, 7'h7F};
    ex_tgt = 3'd0; ex_we = 1'b1; ex_res = 16'h1234;
    step("addi_r0");
    check("addi_r0.imm_abs", 32'(o_imm), 32'hFFFF);
    check("addi_r0.op1_abs", 32'(o_op1), 32'd0);

    // Hold for three cycles while the decoder sees other instructions, then flush
    clear_inputs();
    instr = {3'b100, 3'd5, 3'd6, 7'h41}; valid = 1'b1; pc = 16'h0100;
    step("sw");
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; instr = 16'($urandom); pc = 16'($urandom);
      step("hold");
      check("hold.pc_abs", 32'(o_pc), 32'h0100);
    end
    flush = 1'b1;
    step("flush");
    flush = 1'b0; stall = 1'b0;

    // Reset mid-hold with a load-use hazard present
    instr = {3'b000, 3'd3, 3'd1, 4'b0, 3'd2}; valid = 1'b1; pc = 16'h0200;
    step("pre_rst");
    stall = 1'b1; ex_tgt = 3'd1; ex_we = 1'b1; ex_ld = 1'b1;
    apply_reset("rst_hold");
    step("post_rst_hold");
    stall = 1'b0; ex_ld = 1'b0;
    step("post_rst_resume");

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) apply_reset("rand_rst");
      rand_inputs();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
